// File: rtl/switch_event_pkg.sv
// Shared types and board defaults for the switch event decoder.
// State encoding plus cycle counts for the 25 MHz board clock.
package switch_event_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    HELD      = 3'd1,
    LONG_HELD = 3'd2,
    GAP       = 3'd3,
    HELD2     = 3'd4
  } state_e;

  localparam int CNT_W_DEF  = 24;
  localparam int LONG_DEF   = 12_500_000;
  localparam int DOUBLE_DEF = 6_250_000;
  localparam int REPEAT_DEF = 2_500_000;

endpackage

// File: rtl/switch_edge_detect.sv
// Rise/fall detector on an already-synchronous level.
// Edges are combinational against the previous-level register.
module switch_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise,
  output logic fall
);

  logic prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= level;
  end

  assign rise = level & ~prev_q;
  assign fall = ~level & prev_q;

endmodule

// File: rtl/switch_event_decoder.sv
// Classifies debounced switch activity into one-cycle event pulses:
// press, release, short click, double click, long press, auto-repeat.
import switch_event_pkg::*;

module switch_event_decoder #(
  parameter int COUNTER_WIDTH = CNT_W_DEF,
  parameter int LONG_CYCLES   = LONG_DEF,
  parameter int DOUBLE_CYCLES = DOUBLE_DEF,
  parameter int REPEAT_CYCLES = REPEAT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_Switch,
  output logic o_Press,
  output logic o_Release,
  output logic o_Short,
  output logic o_Double,
  output logic o_Long,
  output logic o_Repeat
);

  if (LONG_CYCLES < 2 || (LONG_CYCLES >> COUNTER_WIDTH) != 0) begin : g_bad_long
    $error("LONG_CYCLES out of range");
  end
  if (DOUBLE_CYCLES < 2 || (DOUBLE_CYCLES >> COUNTER_WIDTH) != 0) begin : g_bad_dbl
    $error("DOUBLE_CYCLES out of range");
  end
  if (REPEAT_CYCLES < 2 || (REPEAT_CYCLES >> COUNTER_WIDTH) != 0) begin : g_bad_rep
    $error("REPEAT_CYCLES out of range");
  end

  localparam logic [COUNTER_WIDTH-1:0] LONG_M1 =
    COUNTER_WIDTH'(LONG_CYCLES - 1);
  localparam logic [COUNTER_WIDTH-1:0] DBL_M1 =
    COUNTER_WIDTH'(DOUBLE_CYCLES - 1);
  localparam logic [COUNTER_WIDTH-1:0] REP_M1 =
    COUNTER_WIDTH'(REPEAT_CYCLES - 1);

  logic rise, fall;

  switch_edge_detect u_edge (
    .clk   (clk),
    .rst   (rst),
    .level (i_Switch),
    .rise  (rise),
    .fall  (fall)
  );

  state_e                   state_q;
  logic [COUNTER_WIDTH-1:0] cnt_q;
  logic press_q, release_q, short_q;
  logic double_q, long_q, repeat_q;

  // Edges take priority over timer expiry in every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      short_q   <= 1'b0;
      double_q  <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      short_q   <= 1'b0;
      double_q  <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (rise) begin
            state_q <= HELD;
            press_q <= 1'b1;
          end
        end
        HELD: begin
          if (fall) begin
            state_q   <= GAP;
            cnt_q     <= '0;
            release_q <= 1'b1;
          end else if (cnt_q == LONG_M1) begin
            state_q <= LONG_HELD;
            cnt_q   <= '0;
            long_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        LONG_HELD: begin
          if (fall) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            release_q <= 1'b1;
          end else if (cnt_q == REP_M1) begin
            cnt_q    <= '0;
            repeat_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        GAP: begin
          if (rise) begin
            state_q  <= HELD2;
            cnt_q    <= '0;
            press_q  <= 1'b1;
            double_q <= 1'b1;
          end else if (cnt_q == DBL_M1) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            short_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        HELD2: begin
          if (fall) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            release_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign o_Press   = press_q;
  assign o_Release = release_q;
  assign o_Short   = short_q;
  assign o_Double  = double_q;
  assign o_Long    = long_q;
  assign o_Repeat  = repeat_q;

endmodule
